// File: rtl/apb_master_pkg.sv
// rtl/apb_master_pkg.sv - shared types for the APB master bridge
package apb_master_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic        timeout;
   } rsp_t;

endpackage

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - valid/ready command port to APB3 initiator with timeout
module apb_master_bridge
   import apb_master_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic                      req_write_i,
   input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
   input  logic [31:0]               req_wdata_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [31:0]               rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      rsp_timeout_o,
   output logic [APB_ADDR_WIDTH-1:0] PADDR,
   output logic [31:0]               PWDATA,
   output logic                      PWRITE,
   output logic                      PSEL,
   output logic                      PENABLE,
   input  logic [31:0]               PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   // A zero TIMEOUT_CYCLES still needs a 1-bit counter so the logic stays well formed.
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic TO_EN = (TIMEOUT_CYCLES > 0);
   localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] to_cnt;
   logic             to_hit;
   logic             accept;
   logic             xfer_done;
   logic             xfer_abort;
   rsp_t             rsp_q;

   assign accept = (state == IDLE) && req_valid_i;

   // Next-state decode; PREADY wins over a timeout expiring in the same cycle.
   always_comb begin
      state_nxt  = state;
      xfer_done  = 1'b0;
      xfer_abort = 1'b0;
      to_hit     = TO_EN && (to_cnt == TO_LAST);
      case (state)
         IDLE: begin
            if (req_valid_i) begin
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            state_nxt = ACCESS;
         end
         ACCESS: begin
            if (PREADY) begin
               state_nxt = RESP;
               xfer_done = 1'b1;
            end else if (to_hit) begin
               state_nxt  = RESP;
               xfer_abort = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register plus handshake/strobe flops decoded from the next state.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state       <= IDLE;
         req_ready_o <= 1'b1;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         rsp_valid_o <= 1'b0;
      end else begin
         state       <= state_nxt;
         req_ready_o <= (state_nxt == IDLE);
         PSEL        <= (state_nxt == SETUP) || (state_nxt == ACCESS);
         PENABLE     <= (state_nxt == ACCESS);
         rsp_valid_o <= (state_nxt == RESP);
      end
   end

   // Command fields latched at acceptance and held until the next accepted command.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         PADDR  <= '0;
         PWDATA <= '0;
         PWRITE <= 1'b0;
      end else if (accept) begin
         PADDR  <= req_addr_i;
         PWDATA <= req_wdata_i;
         PWRITE <= req_write_i;
      end
   end

   // Wait-state counter: cleared in SETUP so it starts at zero on ACCESS entry.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         to_cnt <= '0;
      end else if (state == SETUP) begin
         to_cnt <= '0;
      end else if ((state == ACCESS) && !PREADY && TO_EN) begin
         to_cnt <= to_cnt + CNT_W'(1);
      end
   end

   // Response capture; read data is suppressed for writes, slave errors and aborts.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         rsp_q <= '0;
      end else if (xfer_done) begin
         rsp_q.rdata   <= (PWRITE || PSLVERR) ? 32'h0 : PRDATA;
         rsp_q.err     <= PSLVERR;
         rsp_q.timeout <= 1'b0;
      end else if (xfer_abort) begin
         rsp_q.rdata   <= 32'h0;
         rsp_q.err     <= 1'b1;
         rsp_q.timeout <= 1'b1;
      end
   end

   assign rsp_rdata_o   = rsp_q.rdata;
   assign rsp_err_o     = rsp_q.err;
   assign rsp_timeout_o = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        req_valid, req_ready, req_write;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [11:0] paddr;
   logic [31:0] pwdata, prdata;
   logic        pwrite, psel, penable, pready, pslverr;

   logic        b_req_valid, b_req_ready, b_req_write;
   logic [11:0] b_req_addr;
   logic [31:0] b_req_wdata;
   logic        b_rsp_valid, b_rsp_ready, b_rsp_err, b_rsp_timeout;
   logic [31:0] b_rsp_rdata;
   logic [11:0] b_paddr;
   logic [31:0] b_pwdata, b_prdata;
   logic        b_pwrite, b_psel, b_penable, b_pready, b_pslverr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   apb_master_bridge #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(8)) dut (
      .HCLK(clk), .HRESETn(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
      .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
      .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite), .PSEL(psel), .PENABLE(penable),
      .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
   );

   apb_master_bridge #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(0)) dut_nto (
      .HCLK(clk), .HRESETn(rst_n),
      .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_write_i(b_req_write),
      .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
      .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata),
      .rsp_err_o(b_rsp_err), .rsp_timeout_o(b_rsp_timeout),
      .PADDR(b_paddr), .PWDATA(b_pwdata), .PWRITE(b_pwrite), .PSEL(b_psel), .PENABLE(b_penable),
      .PRDATA(b_prdata), .PREADY(b_pready), .PSLVERR(b_pslverr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [11:0] addr, input logic [31:0] wdata);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
      checks++; if ({psel, penable, pwrite} !== 3'b000) begin errors++; $display("FAIL reset_apb_ctl got %b exp 000", {psel, penable, pwrite}); end
      checks++; if ({paddr, pwdata} !== 44'h0) begin errors++; $display("FAIL reset_apb_data got %h exp 0", {paddr, pwdata}); end
      checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b000) begin errors++; $display("FAIL reset_rsp_flags got %b exp 000", {rsp_valid, rsp_err, rsp_timeout}); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_zero_wait_write();
      pready = 1'b1;
      issue(1'b1, 12'h010, 32'hDEADBEEF);
      checks++; if ({psel, penable, req_ready} !== 3'b100) begin errors++; $display("FAIL zw_setup got %b exp 100", {psel, penable, req_ready}); end
      checks++; if ({paddr, pwdata, pwrite} !== {12'h010, 32'hDEADBEEF, 1'b1}) begin errors++; $display("FAIL zw_cmd got %h/%h/%b exp 010/deadbeef/1", paddr, pwdata, pwrite); end
      tick();
      checks++; if ({psel, penable, rsp_valid} !== 3'b110) begin errors++; $display("FAIL zw_access got %b exp 110", {psel, penable, rsp_valid}); end
      tick();
      checks++; if ({rsp_valid, rsp_err, rsp_timeout, psel, penable} !== 5'b10000) begin errors++; $display("FAIL zw_resp got %b exp 10000", {rsp_valid, rsp_err, rsp_timeout, psel, penable}); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL zw_rdata got %h exp 0", rsp_rdata); end
      tick();
      checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL zw_idle got %b exp 01", {rsp_valid, req_ready}); end
      checks++; if ({paddr, pwdata} !== {12'h010, 32'hDEADBEEF}) begin errors++; $display("FAIL zw_hold got %h/%h exp 010/deadbeef", paddr, pwdata); end
   endtask

   task automatic test_read_wait3();
      pready = 1'b0;
      prdata = 32'h0;
      issue(1'b0, 12'h024, 32'h0);
      tick();
      for (int i = 0; i < 4; i++) begin
         checks++; if ({psel, penable, rsp_valid, pwrite, paddr} !== {4'b1100, 12'h024}) begin errors++; $display("FAIL rd_access%0d got %b%b%b%b/%h exp 1100/024", i, psel, penable, rsp_valid, pwrite, paddr); end
         if (i == 3) begin
            pready = 1'b1;
            prdata = 32'h12345678;
         end
         tick();
      end
      pready = 1'b0;
      prdata = 32'hFFFFFFFF;
      checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100) begin errors++; $display("FAIL rd_resp got %b exp 100", {rsp_valid, rsp_err, rsp_timeout}); end
      checks++; if (rsp_rdata !== 32'h12345678) begin errors++; $display("FAIL rd_rdata got %h exp 12345678", rsp_rdata); end
      tick();
   endtask

   task automatic test_slave_error();
      pready  = 1'b1;
      pslverr = 1'b1;
      prdata  = 32'hAAAA5555;
      issue(1'b0, 12'h100, 32'h0);
      tick();
      tick();
      pslverr = 1'b0;
      checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110) begin errors++; $display("FAIL err_flags got %b exp 110", {rsp_valid, rsp_err, rsp_timeout}); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL err_rdata got %h exp 0", rsp_rdata); end
      tick();
   endtask

   task automatic test_timeout();
      pready = 1'b0;
      prdata = 32'h55555555;
      issue(1'b0, 12'h200, 32'h0);
      tick();
      for (int i = 0; i < 8; i++) begin
         checks++; if ({psel, penable, rsp_valid} !== 3'b110) begin errors++; $display("FAIL to_access%0d got %b exp 110", i, {psel, penable, rsp_valid}); end
         tick();
      end
      checks++; if ({psel, penable, rsp_valid, rsp_err, rsp_timeout} !== 5'b00111) begin errors++; $display("FAIL to_resp got %b exp 00111", {psel, penable, rsp_valid, rsp_err, rsp_timeout}); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata got %h exp 0", rsp_rdata); end
      tick();
   endtask

   task automatic test_timeout_boundary();
      pready = 1'b0;
      issue(1'b0, 12'h204, 32'h0);
      tick();
      for (int i = 0; i < 8; i++) begin
         if (i == 7) begin
            pready = 1'b1;
            prdata = 32'h0BADF00D;
         end
         tick();
      end
      pready = 1'b0;
      checks++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100) begin errors++; $display("FAIL tob_flags got %b exp 100", {rsp_valid, rsp_err, rsp_timeout}); end
      checks++; if (rsp_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL tob_rdata got %h exp 0badf00d", rsp_rdata); end
      tick();
   endtask

   task automatic test_no_timeout();
      int bad;
      bad = 0;
      b_pready    = 1'b0;
      b_req_valid = 1'b1;
      b_req_write = 1'b0;
      b_req_addr  = 12'h3F0;
      tick();
      b_req_valid = 1'b0;
      tick();
      for (int i = 0; i < 1000; i++) begin
         if ({b_psel, b_penable, b_rsp_valid} !== 3'b110) bad++;
         if (i == 999) begin
            b_pready = 1'b1;
            b_prdata = 32'h600DCAFE;
         end
         tick();
      end
      b_pready = 1'b0;
      checks++; if (bad !== 0) begin errors++; $display("FAIL nto_hold got %0d bad cycles exp 0", bad); end
      checks++; if ({b_rsp_valid, b_rsp_err, b_rsp_timeout} !== 3'b100) begin errors++; $display("FAIL nto_flags got %b exp 100", {b_rsp_valid, b_rsp_err, b_rsp_timeout}); end
      checks++; if (b_rsp_rdata !== 32'h600DCAFE) begin errors++; $display("FAIL nto_rdata got %h exp 600dcafe", b_rsp_rdata); end
      tick();
   endtask

   task automatic test_backpressure();
      int bad;
      bad = 0;
      rsp_ready = 1'b0;
      pready    = 1'b1;
      prdata    = 32'hCAFEF00D;
      issue(1'b0, 12'h0C0, 32'h0);
      tick();
      tick();
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 12'h7FF;
      for (int i = 0; i < 5; i++) begin
         prdata = 32'h11111111 * (i + 1);
         if ({rsp_valid, rsp_err, rsp_timeout, req_ready, psel} !== 5'b10000) bad++;
         if (rsp_rdata !== 32'hCAFEF00D) bad++;
         tick();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      checks++; if (bad !== 0) begin errors++; $display("FAIL bp_stable got %0d bad samples exp 0", bad); end
      checks++; if (paddr !== 12'h0C0) begin errors++; $display("FAIL bp_no_accept got %h exp 0c0", paddr); end
      tick();
      checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL bp_release got %b exp 01", {rsp_valid, req_ready}); end
      pready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int setups;
      int resps;
      setups = 0;
      resps  = 0;
      pready    = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 12'h040;
      req_wdata = 32'h01020304;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (psel && !penable) setups++;
         if (rsp_valid) resps++;
      end
      req_valid = 1'b0;
      checks++; if (setups !== 3) begin errors++; $display("FAIL b2b_setups got %0d exp 3", setups); end
      checks++; if (resps !== 3) begin errors++; $display("FAIL b2b_resps got %0d exp 3", resps); end
      tick();
      pready = 1'b0;
   endtask

   task automatic test_reset_mid();
      pready = 1'b0;
      issue(1'b1, 12'h0AA, 32'h12121212);
      tick();
      checks++; if ({psel, penable} !== 2'b11) begin errors++; $display("FAIL rst_pre got %b exp 11", {psel, penable}); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if ({psel, penable, rsp_valid, req_ready} !== 4'b0001) begin errors++; $display("FAIL rst_async got %b exp 0001", {psel, penable, rsp_valid, req_ready}); end
      checks++; if ({paddr, pwdata, pwrite} !== 45'h0) begin errors++; $display("FAIL rst_async_data got %h exp 0", {paddr, pwdata, pwrite}); end
      tick();
      rst_n = 1'b1;
      pready = 1'b1;
      tick();
      tick();
      checks++; if ({req_ready, rsp_valid, psel} !== 3'b100) begin errors++; $display("FAIL rst_after got %b exp 100", {req_ready, rsp_valid, psel}); end
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b1; prdata = '0; pready = 1'b0; pslverr = 1'b0;
      b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
      b_rsp_ready = 1'b1; b_prdata = '0; b_pready = 1'b0; b_pslverr = 1'b0;
      test_reset();
      test_zero_wait_write();
      test_read_wait3();
      test_slave_error();
      test_timeout();
      test_timeout_boundary();
      test_no_timeout();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
